// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter in front of the UART send FIFO write port.
// Optional stall timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned IDLE_TIMEOUT = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_wen,
  output logic [7:0]           tx_wdata,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_o
);

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned DW      = 8;
  localparam int unsigned IDW     = 3;
  localparam int unsigned PADW    = DW * MAX_REQ;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state, state_next;
  logic [IDW-1:0]       last_grant, last_grant_next;
  logic [IDW-1:0]       grant_next;
  logic                 busy_next;

  logic [MAX_REQ-1:0]   valid_pad, last_pad, ready_pad;
  logic [PADW-1:0]      data_pad;
  logic [IDW-1:0]       sel, cand;
  logic                 any_sel;
  int unsigned          idx_sum;
  logic                 xfer;

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0]           stall_cnt, stall_cnt_next;
  logic                 timeout_next;
`endif

  // Zero-extend requester buses to the 8-wide maximum so indexing is uniform
  always_comb begin
    valid_pad = MAX_REQ'(req_valid);
    last_pad  = MAX_REQ'(req_last);
    data_pad  = PADW'(req_data);
  end

  // Round-robin pick: first valid requester after last_grant, wrapping
  always_comb begin
    sel     = last_grant;
    any_sel = 1'b0;
    idx_sum = 0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_sum = 32'(last_grant) + k;
      if (idx_sum >= NUM_REQ) idx_sum = idx_sum - NUM_REQ;
      cand = IDW'(idx_sum);
      if (!any_sel && valid_pad[cand]) begin
        any_sel = 1'b1;
        sel     = cand;
      end
    end
  end

  // Next-state and pass-through datapath
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant_next      = grant_id;
    ready_pad       = '0;
    tx_wen          = 1'b0;
    tx_wdata        = '0;
    xfer            = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_cnt_next  = stall_cnt;
    timeout_next    = 1'b0;
`endif

    case (state)
      IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
        stall_cnt_next = '0;
`endif
        if (any_sel) begin
          grant_next = sel;
          state_next = LOCK;
        end
      end
      LOCK: begin
        xfer      = valid_pad[grant_id] & tx_ready;
        tx_wen    = xfer;
        tx_wdata  = data_pad[{grant_id, 3'b000} +: DW];
        ready_pad = MAX_REQ'(tx_ready) << grant_id;
        if (xfer && last_pad[grant_id]) begin
          state_next      = IDLE;
          last_grant_next = grant_id;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Only an absent owner counts as a stall; FIFO backpressure never does
        if (xfer) begin
          stall_cnt_next = '0;
        end else if (!valid_pad[grant_id]) begin
          if (stall_cnt == 8'(IDLE_TIMEOUT)) begin
            state_next      = IDLE;
            last_grant_next = grant_id;
            timeout_next    = 1'b1;
          end else begin
            stall_cnt_next = stall_cnt + 8'd1;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == LOCK);
  end

  assign req_ready = ready_pad[NUM_REQ-1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      grant_id   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      grant_id   <= grant_next;
      busy       <= busy_next;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stall_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      timeout_o <= timeout_next;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, IDLE_TIMEOUT=3); timeout
// expectations follow UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_wen;
  logic [7:0]  tx_wdata;
  logic        tx_ready;
  logic        busy;
  logic [2:0]  grant_id;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .IDLE_TIMEOUT(3)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_wen    (tx_wen),
    .tx_wdata  (tx_wdata),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .timeout_o (timeout_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    cyc(); cyc();
    sys_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_wen", 32'(tx_wen), 32'd0);
    check("rst_wdata", 32'(tx_wdata), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);

    // Reset priority: requester 0 first, then 1, four cycles in all
    req_valid = 4'b0011; req_last = 4'b0011; req_data = 32'h0000_4241;
    settle();
    check("p_arb_wen", 32'(tx_wen), 32'd0);
    check("p_arb_ready", 32'(req_ready), 32'd0);
    cyc(); settle();
    check("p0_busy", 32'(busy), 32'd1);
    check("p0_grant", 32'(grant_id), 32'd0);
    check("p0_wen", 32'(tx_wen), 32'd1);
    check("p0_data", 32'(tx_wdata), 32'h41);
    check("p0_ready", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'b0010; settle();
    check("p_gap_busy", 32'(busy), 32'd0);
    check("p_gap_wen", 32'(tx_wen), 32'd0);
    cyc(); settle();
    check("p1_grant", 32'(grant_id), 32'd1);
    check("p1_wen", 32'(tx_wen), 32'd1);
    check("p1_data", 32'(tx_wdata), 32'h42);
    check("p1_ready", 32'(req_ready), 32'b0010);
    cyc(); req_valid = '0; settle();
    check("p_done_busy", 32'(busy), 32'd0);

    // Requester 0 alone so requester 1 is next in rotation
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_0055;
    cyc(); settle();
    check("s0_grant", 32'(grant_id), 32'd0);
    check("s0_data", 32'(tx_wdata), 32'h55);
    cyc(); req_valid = '0;

    // Frame atomicity: requester 1 holds the path while 0 waits
    req_valid = 4'b0011; req_last = 4'b0000; req_data = 32'h0000_10AA;
    cyc(); settle();
    check("fa_grant", 32'(grant_id), 32'd1);
    check("fa_b0_data", 32'(tx_wdata), 32'h10);
    check("fa_b0_ready", 32'(req_ready), 32'b0010);
    cyc(); req_data = 32'h0000_11AA; settle();
    check("fa_b1_wen", 32'(tx_wen), 32'd1);
    check("fa_b1_data", 32'(tx_wdata), 32'h11);
    check("fa_b1_ready", 32'(req_ready), 32'b0010);
    cyc(); req_data = 32'h0000_12AA; req_last = 4'b0010; settle();
    check("fa_b2_data", 32'(tx_wdata), 32'h12);
    check("fa_b2_ready", 32'(req_ready), 32'b0010);
    cyc(); req_valid = 4'b0001; req_last = 4'b0001; settle();
    check("fa_idle_busy", 32'(busy), 32'd0);
    cyc(); settle();
    check("fa_next_grant", 32'(grant_id), 32'd0);
    check("fa_next_data", 32'(tx_wdata), 32'hAA);
    cyc(); req_valid = '0; req_last = '0;

    // Backpressure: requester 2, FIFO full for 5 cycles after first byte
    req_valid = 4'b0100; req_data = 32'h0020_0000;
    cyc(); settle();
    check("bp_grant", 32'(grant_id), 32'd2);
    check("bp_b0_data", 32'(tx_wdata), 32'h20);
    check("bp_b0_wen", 32'(tx_wen), 32'd1);
    cyc(); req_data = 32'h0021_0000; tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_stall_wen", 32'(tx_wen), 32'd0);
      check("bp_stall_ready", 32'(req_ready), 32'd0);
      check("bp_stall_busy", 32'(busy), 32'd1);
      cyc();
    end
    tx_ready = 1'b1; settle();
    check("bp_b1_wen", 32'(tx_wen), 32'd1);
    check("bp_b1_data", 32'(tx_wdata), 32'h21);
    cyc(); req_data = 32'h0022_0000; req_last = 4'b0100; settle();
    check("bp_b2_wen", 32'(tx_wen), 32'd1);
    check("bp_b2_data", 32'(tx_wdata), 32'h22);
    cyc(); req_valid = '0; req_last = '0; settle();
    check("bp_done_busy", 32'(busy), 32'd0);

    // Rotation: all four send single-byte frames continuously
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h3332_3130;
    for (int i = 0; i < 6; i++) begin
      settle();
      check("rr_idle_busy", 32'(busy), 32'd0);
      cyc(); settle();
      check("rr_grant", 32'(grant_id), 32'(i % 4));
      check("rr_data", 32'(tx_wdata), 32'h30 + 32'(i % 4));
      cyc();
    end
    req_valid = '0; req_last = '0;
    cyc();

    // Reset mid-frame: 4-byte frame from requester 3 cut after byte 2
    req_valid = 4'b1000; req_data = 32'h4000_0000;
    cyc(); settle();
    check("rm_grant", 32'(grant_id), 32'd3);
    check("rm_b0_data", 32'(tx_wdata), 32'h40);
    cyc(); req_data = 32'h4100_0000; settle();
    check("rm_b1_data", 32'(tx_wdata), 32'h41);
    cyc(); sys_rst = 1'b1;
    cyc(); sys_rst = 1'b0; settle();
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_wen", 32'(tx_wen), 32'd0);
    check("rm_grant_rst", 32'(grant_id), 32'd0);
    req_valid = '0;
    cyc();

    // Timeout: requester 0 sends a non-last byte then goes silent
    req_valid = 4'b0001; req_data = 32'h0000_0050;
    cyc(); settle();
    check("to_grant", 32'(grant_id), 32'd0);
    check("to_b0_wen", 32'(tx_wen), 32'd1);
    cyc(); req_valid = 4'b0010; req_last = 4'b0010; req_data = 32'h0000_6100;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      settle();
      check("to_wait_busy", 32'(busy), 32'd1);
      check("to_wait_pulse", 32'(timeout_o), 32'd0);
      check("to_wait_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    settle();
    check("to_pulse", 32'(timeout_o), 32'd1);
    check("to_busy_fall", 32'(busy), 32'd0);
    cyc(); settle();
    check("to_pulse_end", 32'(timeout_o), 32'd0);
    check("to_next_grant", 32'(grant_id), 32'd1);
    check("to_next_data", 32'(tx_wdata), 32'h61);
`else
    for (int i = 0; i < 20; i++) begin
      settle();
      check("nto_busy", 32'(busy), 32'd1);
      check("nto_pulse", 32'(timeout_o), 32'd0);
      check("nto_grant", 32'(grant_id), 32'd0);
      cyc();
    end
`endif
    req_valid = '0; req_last = '0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-atomic round-robin arbiter that shares the single UART transmit path between up to eight byte-stream requesters, for example the CPU APB port, a debug console and a DMA log channel. It sits directly in front of the UART send preprocess FIFO write port and drives its write-enable and write-data. A requester that wins keeps the path until it delivers a byte marked `last`, so multi-byte messages never interleave.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `IDLE_TIMEOUT`, default 255: number of stalled cycles in LOCK before a forced release. Used only when `UART_ARB_TIMEOUT_EN` is defined. Legal range 1..255.

Ports (single clock; reset is synchronous and active-high):
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  qualifies the byte as the final byte of a frame.
- `req_ready`  out  NUM_REQ  per-requester byte accepted this cycle.
- `tx_wen`  out  1  write strobe to the send FIFO.
- `tx_wdata`  out  8  byte to the send FIFO.
- `tx_ready`  in  1  send FIFO not full.
- `busy`  out  1  high while in LOCK.
- `grant_id`  out  3  index of the current or most recent owner.
- `timeout_o`  out  1  one-cycle pulse on a forced release.

## Operation
The arbiter has two states, IDLE and LOCK.
- **IDLE:**
  - `tx_wen` = 0 and `req_ready` = 0.
  - If any `req_valid` bit is set, select the first set bit searching upward from `last_grant+1` modulo NUM_REQ.
  - Register the selection into `grant_id`, then go to LOCK.
  - No byte transfers in the arbitration cycle.
- **LOCK (owner g = `grant_id`):**
  - `tx_wen` = `req_valid[g] & tx_ready`.
  - `tx_wdata` = `req_data[g]`.
  - `req_ready[g]` = `tx_ready`; every other `req_ready` bit is 0. These are combinational pass-throughs with no added pipeline stage.
  - A transfer occurs when `req_valid[g] & tx_ready`.
  - A transfer with `req_last[g]` = 1 sets `last_grant` to g and returns to IDLE on the next edge.
  - Any other transfer, or no transfer, stays in LOCK.
- **Requester rules:** while `req_valid[g]` is high, the requester must hold `req_data` and `req_last` stable until the byte is accepted. The arbiter does not check this.
- **Fairness:** round-robin rotation at frame granularity. Requesters that do not hold the grant are ignored while the arbiter is in LOCK.
- **Reset values:**
  - State = IDLE and `last_grant` = NUM_REQ-1, so requester 0 has first priority after reset.
  - `grant_id` = 0, `busy` = 0, `tx_wen` = 0, `tx_wdata` = 0 (forced to 0 in IDLE).
  - `req_ready` = 0, `timeout_o` = 0.
- **Reset mid-frame:** reset abandons the frame immediately. No partial-state flush is performed; the requester is responsible for the frame restart.
- **`tx_ready` low (FIFO full):** the owner stalls and the arbiter stays in LOCK. `tx_wen` is never asserted while `tx_ready` is low.

## Timing
- **Arbitration latency:** 1 cycle. A request arriving in IDLE at cycle t gives LOCK and a possible first transfer at cycle t+1.
- **Throughput:**
  - Inside a frame: 1 byte per cycle while `tx_ready` is high.
  - A single-byte frame costs 2 cycles (arbitration plus transfer).
  - Back-to-back frames incur one IDLE cycle between them.
- **Simultaneous last-transfer and new requests:** the new owner is chosen in the following IDLE cycle using the updated `last_grant`.
- **Outputs:** `busy` and `grant_id` are registered. `tx_wen`, `tx_wdata` and `req_ready` are combinational from the registered state and the current inputs.

## Configuration
Macro `UART_ARB_TIMEOUT_EN`:
- **Defined:**
  - An 8-bit stall counter clears on entry to LOCK and on every transfer.
  - It increments each LOCK cycle in which `req_valid[g]` = 0.
  - When the counter equals `IDLE_TIMEOUT` and `req_valid[g]` is still 0, the arbiter returns to IDLE with `last_grant` = g and pulses `timeout_o` for one cycle.
  - Stalls caused by `tx_ready` = 0 while `req_valid[g]` = 1 never count.
- **Undefined:** no counter is built, `timeout_o` is tied to 0, and LOCK is released only by a `last` byte.

## Test plan
- **Reset priority:** after reset, assert `req_valid` = 2'b11, both with `last`=1 and data 0x41/0x42. The FIFO receives 0x41 then 0x42 with `grant_id` 0 then 1, and 4 cycles total from request to completion.
- **Frame atomicity:** requester 1 sends 0x10,0x11,0x12(last) while requester 0 is valid throughout. The FIFO receives 0x10,0x11,0x12 contiguously, `req_ready[0]` stays 0 during the frame, and requester 0 is granted next.
- **Backpressure:** hold `tx_ready` = 0 for 5 cycles mid-frame. `tx_wen` = 0 and `req_ready` = 0 for those cycles, the state stays LOCK, and the frame resumes with no byte lost or duplicated.
- **Rotation fairness with `NUM_REQ` = 4:** all four requesters continuously send single-byte frames. The `grant_id` sequence is 0,1,2,3,0,1.
- **Timeout, with `UART_ARB_TIMEOUT_EN` and `IDLE_TIMEOUT` = 3:**
  - Requester 0 sends a non-last byte, then drops `req_valid`.
  - `timeout_o` pulses, `busy` falls, and requester 1 is granted next.
  - Repeat with the macro undefined: `busy` stays 1 indefinitely.
- **Reset mid-frame:** assert `sys_rst` after the 2nd byte of a 4-byte frame. On the next cycle the state is IDLE, `busy` = 0, `tx_wen` = 0, and `grant_id` = 0.
